// File: rtl/rs_latch_ctrl_pkg.sv
// Shared types and constants for the rs latch sequencer.
package rs_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SETTLE = 2'd2,
        CHECK  = 2'd3
    } state_e;

    localparam logic OP_SET   = 1'b1;
    localparam logic OP_RESET = 1'b0;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rs_latch_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: rotate by ptr, take lowest set bit, rotate back.
module rr_arbiter #(
    parameter int N = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    logic [N-1:0] rot;
    logic [N-1:0] rot_gnt;

    // rot[i] holds req[(ptr+i) mod N], so bit 0 is the highest-priority requester
    assign rot     = N'({req, req} >> ptr);
    assign rot_gnt = rot & (~rot + 1'b1);
    assign gnt     = N'(({rot_gnt, rot_gnt} << ptr) >> N);

endmodule

// File: rtl/rs_latch_ctrl.sv
// Shares one external rs latch among N requesters: round-robin pick, clean s/r pulse,
// settle, read q/n back, acknowledge the winner. All outputs are registered.
module rs_latch_ctrl
    import rs_ctrl_pkg::*;
#(
    parameter int N      = 4,
    parameter int PULSE  = 2,
    parameter int SETTLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic [N-1:0] op,
    output logic [N-1:0] gnt,
    output logic [N-1:0] done,
    output logic         err,
    output logic         busy,
    output logic         s,
    output logic         r,
    input  logic         q,
    input  logic         n
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(max2(PULSE, SETTLE) + 1);

    state_e        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [PW-1:0] ptr, ptr_nxt;
    logic [PW-1:0] win, win_nxt, win_sel;
    logic          op_l, op_nxt, op_sel;
    logic [N-1:0]  arb_gnt, gnt_nxt, done_nxt;
    logic          s_nxt, r_nxt, err_nxt;

    rr_arbiter #(.N(N)) u_arb (
        .req (req),
        .ptr (ptr),
        .gnt (arb_gnt)
    );

    always_comb begin
        win_sel = '0;
        for (int i = 0; i < N; i++)
            if (arb_gnt[i]) win_sel = PW'(i);
    end

    assign op_sel = |(op & arb_gnt);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            ptr   <= '0;
            win   <= '0;
            op_l  <= OP_RESET;
            gnt   <= '0;
            done  <= '0;
            err   <= 1'b0;
            busy  <= 1'b0;
            s     <= 1'b0;
            r     <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            ptr   <= ptr_nxt;
            win   <= win_nxt;
            op_l  <= op_nxt;
            gnt   <= gnt_nxt;
            done  <= done_nxt;
            err   <= err_nxt;
            busy  <= (state_nxt != IDLE);
            s     <= s_nxt;
            r     <= r_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ptr_nxt   = ptr;
        win_nxt   = win;
        op_nxt    = op_l;
        gnt_nxt   = gnt;
        done_nxt  = '0;
        err_nxt   = err;
        s_nxt     = s;
        r_nxt     = r;
        case (state)
            IDLE: begin
                if (|req) begin
                    win_nxt   = win_sel;
                    op_nxt    = op_sel;
                    gnt_nxt   = arb_gnt;
                    s_nxt     = (op_sel == OP_SET);
                    r_nxt     = (op_sel == OP_RESET);
                    cnt_nxt   = CW'(PULSE - 1);
                    state_nxt = DRIVE;
                end
            end
            DRIVE: begin
                if (cnt == '0) begin
                    s_nxt     = 1'b0;
                    r_nxt     = 1'b0;
                    cnt_nxt   = CW'(SETTLE - 1);
                    state_nxt = rs_ctrl_pkg::SETTLE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            rs_ctrl_pkg::SETTLE: begin
                // readback is sampled at the edge that enters CHECK; done is visible during CHECK
                if (cnt == '0) begin
                    if (!(q == op_l && n == !op_l)) err_nxt = 1'b1;
                    done_nxt  = gnt;
                    state_nxt = CHECK;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            CHECK: begin
                gnt_nxt   = '0;
                ptr_nxt   = (win == PW'(N - 1)) ? '0 : win + 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_rs_latch_ctrl.sv
// Directed + randomized bench for rs_latch_ctrl with a behavioural latch and transaction-level reference.
module tb_rs_latch_ctrl;

    localparam int N = 4;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] req, op, gnt, done;
    logic         err, busy, s, r, q, n;
    logic         lq, bad;

    int errors = 0;
    int checks = 0;
    int ref_ptr = 0;
    bit ref_err = 1'b0;

    rs_latch_ctrl #(.N(N), .PULSE(2), .SETTLE(1)) dut (
        .clk (clk), .rst_n (rst_n), .req (req), .op (op),
        .gnt (gnt), .done (done), .err (err), .busy (busy),
        .s (s), .r (r), .q (q), .n (n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural latch; bad forces q=n=0 to emulate a broken cell
    initial lq = 1'b0;
    always @(s or r) begin
        if (s && !r)      lq = 1'b1;
        else if (r && !s) lq = 1'b0;
    end
    assign q = bad ? 1'b0 : lq;
    assign n = bad ? 1'b0 : ~lq;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // first requester at or after the pointer, walking cyclically
    function automatic int ref_pick(input logic [N-1:0] rq, input int p);
        for (int d = 0; d < N; d++)
            if (rq[(p + d) % N]) return (p + d) % N;
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // one full operation starting in an IDLE cycle; ends after the IDLE cycle that follows done
    task automatic run_op(input logic [N-1:0] rq, input logic [N-1:0] opv, input bit bad_op,
                          input bit drop_mid, input bit hold, input string tag);
        int           w;
        logic         eop;
        logic [N-1:0] eg;
        bit           perr;
        w    = ref_pick(rq, ref_ptr);
        eg   = N'(1) << w;
        eop  = opv[w];
        perr = ref_err;
        req  = rq;
        op   = opv;
        for (int t = 1; t <= 5; t++) begin
            step();
            chk({tag, ":s&r"}, 32'(s & r), 32'd0);
            if (t <= 2) begin
                chk({tag, ":gnt"}, 32'(gnt), 32'(eg));
                chk({tag, ":s"}, 32'(s), 32'(eop));
                chk({tag, ":r"}, 32'(r), 32'(!eop));
                chk({tag, ":busy"}, 32'(busy), 32'd1);
                chk({tag, ":done"}, 32'(done), 32'd0);
                chk({tag, ":err"}, 32'(err), 32'(perr));
            end else if (t == 3) begin
                chk({tag, ":gnt"}, 32'(gnt), 32'(eg));
                chk({tag, ":s_settle"}, 32'(s), 32'd0);
                chk({tag, ":r_settle"}, 32'(r), 32'd0);
                chk({tag, ":busy"}, 32'(busy), 32'd1);
                chk({tag, ":done"}, 32'(done), 32'd0);
            end else if (t == 4) begin
                chk({tag, ":done_pulse"}, 32'(done), 32'(eg));
                chk({tag, ":gnt_chk"}, 32'(gnt), 32'(eg));
                chk({tag, ":busy"}, 32'(busy), 32'd1);
                chk({tag, ":err_chk"}, 32'(err), 32'(perr | bad_op));
                if (!bad_op) begin
                    chk({tag, ":q"}, 32'(q), 32'(eop));
                    chk({tag, ":n"}, 32'(n), 32'(!eop));
                end
            end else begin
                chk({tag, ":gnt_idle"}, 32'(gnt), 32'd0);
                chk({tag, ":done_idle"}, 32'(done), 32'd0);
                chk({tag, ":busy_idle"}, 32'(busy), 32'd0);
                chk({tag, ":err_idle"}, 32'(err), 32'(ref_err));
            end
            if (t == 1) op = ~opv;
            if (t == 3) begin
                bad = bad_op;
                if (drop_mid) req[w] = 1'b0;
            end
            if (t == 4) begin
                bad     = 1'b0;
                op      = opv;
                ref_err = perr | bad_op;
                ref_ptr = (w + 1) % N;
                if (!hold) req[w] = 1'b0;
            end
        end
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        step();
        rst_n   = 1'b1;
        ref_ptr = 0;
        ref_err = 1'b0;
    endtask

    initial begin
        logic [N-1:0] rq, opv;
        int           w;
        bit           bo, hd;

        rst_n = 1'b0;
        req   = '0;
        op    = '0;
        bad   = 1'b0;
        step();
        step();
        chk("rst:s", 32'(s), 32'd0);
        chk("rst:r", 32'(r), 32'd0);
        chk("rst:gnt", 32'(gnt), 32'd0);
        chk("rst:done", 32'(done), 32'd0);
        chk("rst:err", 32'(err), 32'd0);
        chk("rst:busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        step();

        run_op(4'b0001, 4'b0001, 1'b0, 1'b0, 1'b0, "t1_set");
        run_op(4'b0010, 4'b0000, 1'b0, 1'b0, 1'b0, "t2_reset");

        pulse_reset();
        for (int i = 0; i < 5; i++) run_op(4'b1111, N'($urandom), 1'b0, 1'b0, 1'b1, "t3_rr");
        req = '0;
        step();

        run_op(4'b0100, 4'b0100, 1'b1, 1'b0, 1'b0, "t4_bad");
        run_op(4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0, "t4_sticky_a");
        run_op(4'b1000, 4'b1000, 1'b0, 1'b0, 1'b0, "t4_sticky_b");

        // reset while in DRIVE with the pointer away from 0
        run_op(4'b0010, 4'b0010, 1'b0, 1'b0, 1'b0, "t5_pre");
        rq  = 4'b1010;
        w   = ref_pick(rq, ref_ptr);
        req = rq;
        op  = 4'b1111;
        step();
        chk("t5:gnt_drive", 32'(gnt), 32'(N'(1) << w));
        chk("t5:s_drive", 32'(s), 32'd1);
        rst_n = 1'b0;
        step();
        chk("t5:s", 32'(s), 32'd0);
        chk("t5:r", 32'(r), 32'd0);
        chk("t5:gnt", 32'(gnt), 32'd0);
        chk("t5:busy", 32'(busy), 32'd0);
        chk("t5:done", 32'(done), 32'd0);
        chk("t5:err", 32'(err), 32'd0);
        rst_n   = 1'b1;
        req     = '0;
        ref_ptr = 0;
        ref_err = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("t5:no_done", 32'(done), 32'd0);
            chk("t5:idle", 32'(busy), 32'd0);
        end
        run_op(4'b1111, 4'b0101, 1'b0, 1'b0, 1'b0, "t5_ptr0");

        run_op(4'b0100, 4'b0100, 1'b0, 1'b1, 1'b0, "t6_drop");
        run_op(4'b0100, 4'b0000, 1'b0, 1'b1, 1'b0, "t6_drop_r");

        rq = N'($urandom_range(1, 15));
        for (int i = 0; i < 24; i++) begin
            opv = N'($urandom);
            bo  = ($urandom_range(0, 5) == 0);
            hd  = ($urandom_range(0, 1) == 1);
            run_op(rq, opv, bo, 1'b0, hd, "rnd");
            rq = req | N'($urandom_range(0, 15) & $urandom_range(0, 15));
            if (rq == '0) rq = N'($urandom_range(1, 15));
        end
        req = '0;
        step();

        pulse_reset();
        chk("end:err_cleared", 32'(err), 32'd0);
        chk("end:busy", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
